// File: rtl/memory_responder_pkg.sv
// Shared types and read-latency constant for the instruction memory responder.
// Configuration macro: INSTR_MEM_OUT_REG_EN (extra output register, 2-cycle read latency).
package memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_t;

`ifdef INSTR_MEM_OUT_REG_EN
    localparam int READ_LATENCY = 2;
`else
    localparam int READ_LATENCY = 1;
`endif

endpackage

// File: rtl/memory_read_iface.sv
// Single arbitrated instruction-fetch port: requester drives addr/valid, responder returns ready/data.
interface memory_read_iface #(
    parameter int MEMORY_WIDTH = 16,
    parameter int ADDR_WIDTH   = 11
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    valid;
    logic                    ready;
    logic [MEMORY_WIDTH-1:0] data;

    modport in  (input addr, input valid, output ready, output data);
    modport out (output addr, output valid, input ready, input data);
endinterface

// File: rtl/bram_1r1w.sv
// Inferred simple dual-port block RAM: one synchronous read port, one write port, read-first.
module bram_1r1w #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on purpose: contents and read register must map onto a plain BRAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instruction_memory_responder.sv
// Program store for the regex engines: host load port, load/serve FSM, fixed-latency reads.
// Configuration macro: INSTR_MEM_OUT_REG_EN adds an output register (2-cycle read latency).
module instruction_memory_responder
    import memory_responder_pkg::*;
#(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int READ_COUNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    memory_read_iface.in                  memory,
    input  logic                          load_start,
    input  logic                          load_done,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [MEMORY_ADDR_WIDTH-1:0]  wr_addr,
    input  logic [MEMORY_WIDTH-1:0]       wr_data,
    output logic                          loading,
    output logic [MEMORY_ADDR_WIDTH:0]    words_loaded,
    output logic [READ_COUNT_WIDTH-1:0]   reads_served
);

    localparam logic [MEMORY_ADDR_WIDTH:0] WORDS_MAX = {1'b1, {MEMORY_ADDR_WIDTH{1'b0}}};

    state_t                        state_reg;
    logic                          ready_reg;
    logic                          wr_ready_reg;
    logic                          loading_reg;
    logic [MEMORY_ADDR_WIDTH:0]    words_loaded_reg;
    logic [READ_COUNT_WIDTH-1:0]   reads_served_reg;
    logic                          rd_valid_reg;
    logic [MEMORY_WIDTH-1:0]       data_reg;
    logic [MEMORY_WIDTH-1:0]       bram_rd_data;
    logic                          rd_en;
    logic                          wr_en;

    assign rd_en = ready_reg & memory.valid;
    assign wr_en = wr_ready_reg & wr_valid;

    bram_1r1w #(
        .WIDTH      (MEMORY_WIDTH),
        .ADDR_WIDTH (MEMORY_ADDR_WIDTH)
    ) u_bram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (memory.addr),
        .rd_data (bram_rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            ready_reg        <= 1'b0;
            wr_ready_reg     <= 1'b0;
            loading_reg      <= 1'b0;
            words_loaded_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        state_reg        <= LOAD;
                        wr_ready_reg     <= 1'b1;
                        loading_reg      <= 1'b1;
                        words_loaded_reg <= '0;
                    end
                end
                LOAD: begin
                    if (wr_valid && words_loaded_reg != WORDS_MAX) begin
                        words_loaded_reg <= words_loaded_reg + (MEMORY_ADDR_WIDTH+1)'(1);
                    end
                    if (load_done) begin
                        state_reg    <= SERVE;
                        ready_reg    <= 1'b1;
                        wr_ready_reg <= 1'b0;
                        loading_reg  <= 1'b0;
                    end
                end
                SERVE: begin
                    if (load_start) begin
                        state_reg        <= LOAD;
                        ready_reg        <= 1'b0;
                        wr_ready_reg     <= 1'b1;
                        loading_reg      <= 1'b1;
                        words_loaded_reg <= '0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    ready_reg    <= 1'b0;
                    wr_ready_reg <= 1'b0;
                    loading_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reads_served_reg <= '0;
        end else if (rd_en && reads_served_reg != {READ_COUNT_WIDTH{1'b1}}) begin
            reads_served_reg <= reads_served_reg + READ_COUNT_WIDTH'(1);
        end
    end

    // rd_valid_reg marks the cycle the BRAM read register holds a fresh word; it is
    // independent of the FSM so a read accepted on the last SERVE cycle still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            data_reg     <= '0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_valid_reg) begin
                data_reg <= bram_rd_data;
            end
        end
    end

`ifdef INSTR_MEM_OUT_REG_EN
    assign memory.data = data_reg;
`else
    assign memory.data = rd_valid_reg ? bram_rd_data : data_reg;
`endif

    assign memory.ready  = ready_reg;
    assign wr_ready      = wr_ready_reg;
    assign loading       = loading_reg;
    assign words_loaded  = words_loaded_reg;
    assign reads_served  = reads_served_reg;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Directed table-driven bench for instruction_memory_responder, valid for either read latency.
module tb_instruction_memory_responder;
    import memory_responder_pkg::*;

    localparam int W  = 16;
    localparam int AW = 11;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, load_done, wr_valid;
    logic          wr_ready, loading;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW:0]   words_loaded;
    logic [CW-1:0] reads_served;

    int total_cnt = 0;
    int pass_cnt  = 0;

    memory_read_iface #(.MEMORY_WIDTH(W), .ADDR_WIDTH(AW)) mem_if ();

    instruction_memory_responder #(
        .MEMORY_WIDTH      (W),
        .MEMORY_ADDR_WIDTH (AW),
        .READ_COUNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memory       (mem_if),
        .load_start   (load_start),
        .load_done    (load_done),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .loading      (loading),
        .words_loaded (words_loaded),
        .reads_served (reads_served)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ls, ld, wv;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        logic          mv;
        logic [AW-1:0] ma;
        logic          e_ready, e_wr_ready, e_loading;
        logic [AW:0]   e_words;
        logic [CW-1:0] e_reads;
        logic [W-1:0]  e_data;   // memory.data after this edge with 1-cycle latency
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic ls, logic ld, logic wv, logic [AW-1:0] wa, logic [W-1:0] wd,
                                logic mv, logic [AW-1:0] ma, logic e_ready, logic e_wr_ready,
                                logic e_loading, logic [AW:0] e_words, logic [CW-1:0] e_reads,
                                logic [W-1:0] e_data);
        vec_t v;
        v.ls = ls; v.ld = ld; v.wv = wv; v.wa = wa; v.wd = wd; v.mv = mv; v.ma = ma;
        v.e_ready = e_ready; v.e_wr_ready = e_wr_ready; v.e_loading = e_loading;
        v.e_words = e_words; v.e_reads = e_reads; v.e_data = e_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive(input logic ls, input logic ld, input logic wv, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input logic mv, input logic [AW-1:0] ma);
        load_start   = ls;
        load_done    = ld;
        wr_valid     = wv;
        wr_addr      = wa;
        wr_data      = wd;
        mem_if.valid = mv;
        mem_if.addr  = ma;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [W-1:0] prev_exp;
        logic [W-1:0] exp_d;

        // IDLE probes, then load 0..3, then reads, then a read overlapping load_start.
        vecs[0]  = mk(0,0,0, 0,16'h0000, 1,0, 0,0,0, 0,0, 16'h0000);
        vecs[1]  = mk(0,1,0, 0,16'h0000, 0,0, 0,0,0, 0,0, 16'h0000);
        vecs[2]  = mk(1,0,0, 0,16'h0000, 0,0, 0,1,1, 0,0, 16'h0000);
        vecs[3]  = mk(0,0,1, 0,16'h0011, 0,0, 0,1,1, 1,0, 16'h0000);
        vecs[4]  = mk(0,0,1, 1,16'h0022, 1,0, 0,1,1, 2,0, 16'h0000);
        vecs[5]  = mk(1,0,1, 2,16'h0033, 0,0, 0,1,1, 3,0, 16'h0000);
        vecs[6]  = mk(0,0,1, 3,16'h0044, 0,0, 0,1,1, 4,0, 16'h0000);
        vecs[7]  = mk(0,1,0, 0,16'h0000, 0,0, 1,0,0, 4,0, 16'h0000);
        vecs[8]  = mk(0,0,0, 0,16'h0000, 1,2, 1,0,0, 4,1, 16'h0033);
        vecs[9]  = mk(0,0,0, 0,16'h0000, 1,0, 1,0,0, 4,2, 16'h0011);
        vecs[10] = mk(0,0,0, 0,16'h0000, 1,3, 1,0,0, 4,3, 16'h0044);
        vecs[11] = mk(0,0,0, 0,16'h0000, 0,0, 1,0,0, 4,3, 16'h0044);
        vecs[12] = mk(1,0,0, 0,16'h0000, 1,1, 0,1,1, 0,4, 16'h0022);
        vecs[13] = mk(0,0,1, 1,16'hBEEF, 0,0, 0,1,1, 1,4, 16'h0022);
        vecs[14] = mk(0,0,1, 1,16'hBEEF, 1,2, 0,1,1, 2,4, 16'h0022);
        vecs[15] = mk(0,1,1, 3,16'h0055, 0,0, 1,0,0, 3,4, 16'h0022);
        vecs[16] = mk(0,0,0, 0,16'h0000, 1,1, 1,0,0, 3,5, 16'hBEEF);
        vecs[17] = mk(0,0,0, 0,16'h0000, 1,3, 1,0,0, 3,6, 16'h0055);
        vecs[18] = mk(0,1,0, 0,16'h0000, 0,0, 1,0,0, 3,6, 16'h0055);
        vecs[19] = mk(0,0,0, 0,16'h0000, 0,0, 1,0,0, 3,6, 16'h0055);

        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready",    32'(mem_if.ready),  32'h0);
        check("rst_data",     32'(mem_if.data),   32'h0);
        check("rst_wr_ready", 32'(wr_ready),      32'h0);
        check("rst_loading",  32'(loading),       32'h0);
        check("rst_words",    32'(words_loaded),  32'h0);
        check("rst_reads",    32'(reads_served),  32'h0);
        rst = 1'b0;

        prev_exp = '0;
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].ls, vecs[i].ld, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].mv, vecs[i].ma);
            tick();
            exp_d    = (READ_LATENCY == 1) ? vecs[i].e_data : prev_exp;
            prev_exp = vecs[i].e_data;
            check($sformatf("v%0d_ready", i),    32'(mem_if.ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d_wr_ready", i), 32'(wr_ready),     32'(vecs[i].e_wr_ready));
            check($sformatf("v%0d_loading", i),  32'(loading),      32'(vecs[i].e_loading));
            check($sformatf("v%0d_words", i),    32'(words_loaded), 32'(vecs[i].e_words));
            check($sformatf("v%0d_reads", i),    reads_served,      vecs[i].e_reads);
            check($sformatf("v%0d_data", i),     32'(mem_if.data),  32'(exp_d));
            $display("vec %0d: ready=%0d wr_ready=%0d loading=%0d words=%0d reads=%0d data=%04h",
                     i, mem_if.ready, wr_ready, loading, words_loaded, reads_served, mem_if.data);
        end

        // Reset the cycle after an accepted read: the in-flight word must never surface.
        drive(0,0,0, 0,16'h0, 1,1);
        tick();
        check("rstmid_first", 32'(mem_if.data), (READ_LATENCY == 1) ? 32'hBEEF : 32'h0055);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_data",  32'(mem_if.data),  32'h0);
        check("rstmid_ready", 32'(mem_if.ready), 32'h0);
        check("rstmid_reads", 32'(reads_served), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstmid_hold%0d", k), 32'(mem_if.data), 32'h0);
        end
        $display("reset mid-read: data=%04h", mem_if.data);

        // Empty reload, then confirm RAM kept 0xBEEF across reset.
        drive(1,0,0, 0,16'h0, 0,0); tick();
        drive(0,1,0, 0,16'h0, 0,0); tick();
        check("reload_words", 32'(words_loaded), 32'h0);
        check("reload_ready", 32'(mem_if.ready), 32'h1);
        drive(0,0,0, 0,16'h0, 1,1); tick();
        idle_inputs();
        if (READ_LATENCY == 2) tick();
        check("retain_data",  32'(mem_if.data),  32'hBEEF);
        check("retain_reads", 32'(reads_served), 32'h1);
        $display("retained read: data=%04h reads=%0d", mem_if.data, reads_served);

        // Saturation of words_loaded.
        drive(1,0,0, 0,16'h0, 0,0); tick();
        for (int n = 0; n < (1 << AW) + 5; n++) begin
            drive(0,0,1, AW'(n), W'(n), 0,0);
            tick();
            if (n == (1 << AW) - 2) begin
                check("sat_below", 32'(words_loaded), 32'((1 << AW) - 1));
            end
        end
        check("sat_words", 32'(words_loaded), 32'(1 << AW));
        drive(0,1,0, 0,16'h0, 0,0); tick();
        idle_inputs();
        check("sat_after_done", 32'(words_loaded), 32'(1 << AW));
        $display("saturation: words=%0d", words_loaded);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
